// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for the pipeline's data-memory port. It accepts one
// load/store request at a time on a valid/ready request channel, performs a
// single word access after a programmable number of clock edges, and returns
// load data or a store acknowledgement on a valid/ready response channel.
// The data-memory array lives inside this block.
//
// Parameters
//    DEPTH_WORDS  number of 32-bit words; legal byte addresses are
//                 0 .. 4*DEPTH_WORDS-1, word aligned
//    LATENCY      edges from request accept to rsp_valid (1..15)
//
// Ports
//    CLK        in   clock, all state changes on the rising edge
//    RESET      in   synchronous active-high reset
//    req_valid  in   request present
//    req_ready  out  responder idle and able to accept a request
//    req_write  in   1 = store, 0 = load
//    req_addr   in   byte address (must be word aligned and in range)
//    req_wdata  in   store data
//    req_be     in   store byte enables, be[i] covers wdata[8i+7:8i]
//    rsp_valid  out  response present
//    rsp_ready  in   initiator takes the response
//    rsp_rdata  out  load data, zero for stores and errors
//    rsp_err    out  request was misaligned or out of range
//    busy       out  responder is not idle
// ---------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH_WORDS = 512,
   parameter int LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  cnt;
   logic [3:0]  cnt_next;

   logic        accept;
   logic        execute;

   logic        write_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   logic          addr_err;
   logic [AW-1:0] word_idx;

   // The array is deliberately outside the reset domain: RESET only stops
   // an in-flight access, it never clears stored data. Contents start at
   // zero when simulation begins.
   logic [31:0] mem [0:DEPTH_WORDS-1] = '{default: '0};

   // Handshake outputs come straight from the state register so the
   // initiator sees ready/valid without any combinational path from its
   // own request or response signals.
   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

   // Error and word index are decoded from the captured address, so the
   // request inputs are free to change once the request has been taken.
   // The range check uses the full upper address so that addresses past
   // the end report an error instead of aliasing onto low words.
   assign addr_err = (addr_q[1:0] != 2'b00) ||
                     ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
   assign word_idx = addr_q[AW+1:2];

   // Next-state logic. A request is taken only in IDLE; the counter then
   // runs down from LATENCY-1 and the access fires on the edge where it is
   // already zero, which puts rsp_valid exactly LATENCY edges after the
   // accept edge. RESP waits for the initiator to take the response.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept     = 1'b0;
      execute    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept     = 1'b1;
               state_next = S_WAIT;
               cnt_next   = 4'(LATENCY - 1);
            end
         end
         S_WAIT: begin
            if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               execute    = 1'b1;
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and latency counter. Reset takes priority over any handshake
   // happening on the same edge, so a request presented together with
   // RESET is never taken and a pending response is simply dropped.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Request capture. Everything the access needs is latched at the accept
   // edge so the request bus is don't-care while the responder is busy.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
      end else if (accept) begin
         write_q <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   // Response registers. They are loaded once, on the edge that performs
   // the access, and then hold their value through any backpressure in
   // RESP. Stores and errored requests return zero data.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (execute) begin
         rsp_err <= addr_err;
         if (!addr_err && !write_q) begin
            rsp_rdata <= mem[word_idx];
         end else begin
            rsp_rdata <= 32'd0;
         end
      end
   end

   // Array write with per-byte enables. Gating with RESET means a reset
   // landing on the access edge discards the store, and an errored store
   // leaves the array untouched. An all-zero byte enable writes nothing but
   // is still acknowledged by the response path above.
   always_ff @(posedge CLK) begin
      if (!RESET && execute && write_q && !addr_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule
